// File: rtl/spi_cmd_sequencer.sv
// Command front end for the spi_top engine: buffers SPI transactions, fires one go pulse
// per command, waits for the engine to finish and queues masked read data for the consumer.
module spi_cmd_sequencer #(
   parameter int unsigned CMD_DEPTH     = 8,
   parameter int unsigned RSP_DEPTH     = 8,
   parameter int unsigned START_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_wdata,
   input  logic [1:0]  cmd_nbytes,
   input  logic        cmd_rd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [31:0] spi_control,
   output logic [31:0] spi_wrdata,
   input  logic [31:0] spi_rddata,
   input  logic [31:0] spi_status,
   output logic        busy,
   output logic        timeout_err
);

   localparam int unsigned CAW      = $clog2(CMD_DEPTH);
   localparam int unsigned RAW      = $clog2(RSP_DEPTH);
   localparam logic [7:0]  TMO_LAST = 8'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE, CAPTURE} state_t;

   state_t       state_q, state_d;

   logic [34:0]  cmd_mem_q [CMD_DEPTH];
   logic [CAW:0] cwr_q, crd_q;
   logic         cmd_empty, cmd_full, cmd_push, cmd_pop;
   logic [34:0]  cmd_head;

   logic [31:0]  rsp_mem_q [RSP_DEPTH];
   logic [RAW:0] rwr_q, rrd_q;
   logic         rsp_empty, rsp_full, rsp_push, rsp_pop;
   logic [31:0]  rsp_wdata;

   logic [31:0]  wdata_q;
   logic [1:0]   nbytes_q;
   logic         rd_q;
   logic [7:0]   timer_q;
   logic         timeout_q;
   logic         start_tmo;
   logic         go;
   logic [31:0]  byte_mask;
   logic         unused_status;

   assign unused_status = ^spi_status[31:1];

   // Full when the pointers differ only in the wrap bit.
   assign cmd_empty = (cwr_q == crd_q);
   assign cmd_full  = (cwr_q[CAW] != crd_q[CAW]) && (cwr_q[CAW-1:0] == crd_q[CAW-1:0]);
   assign cmd_ready = !cmd_full;
   assign cmd_push  = cmd_valid && !cmd_full;
   assign cmd_head  = cmd_mem_q[crd_q[CAW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         cwr_q <= '0;
         crd_q <= '0;
      end else begin
         if (cmd_push) cwr_q <= cwr_q + 1'b1;
         if (cmd_pop)  crd_q <= crd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem_q[cwr_q[CAW-1:0]] <= {cmd_rd, cmd_nbytes, cmd_wdata};
   end

   assign rsp_empty = (rwr_q == rrd_q);
   assign rsp_full  = (rwr_q[RAW] != rrd_q[RAW]) && (rwr_q[RAW-1:0] == rrd_q[RAW-1:0]);
   assign rsp_valid = !rsp_empty;
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign rsp_data  = rsp_mem_q[rrd_q[RAW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         rwr_q <= '0;
         rrd_q <= '0;
      end else begin
         if (rsp_push) rwr_q <= rwr_q + 1'b1;
         if (rsp_pop)  rrd_q <= rrd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_push) rsp_mem_q[rwr_q[RAW-1:0]] <= rsp_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdata_q   <= '0;
         nbytes_q  <= '0;
         rd_q      <= 1'b0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (cmd_pop) {rd_q, nbytes_q, wdata_q} <= cmd_head;
         if (state_q == LAUNCH)          timer_q <= '0;
         else if (state_q == WAIT_START) timer_q <= timer_q + 1'b1;
         if (start_tmo) timeout_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A read only launches when its response is guaranteed a slot.
   always_comb begin
      state_d   = state_q;
      cmd_pop   = 1'b0;
      start_tmo = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!cmd_empty && spi_status[0] && (!cmd_head[34] || !rsp_full)) begin
               cmd_pop = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH:     state_d = WAIT_START;
         WAIT_START: begin
            if (!spi_status[0]) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TMO_LAST) begin
               start_tmo = 1'b1;
               state_d   = IDLE;
            end
         end
         WAIT_DONE:  if (spi_status[0]) state_d = CAPTURE;
         CAPTURE:    state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      go = (state_q == LAUNCH);
      unique case (nbytes_q)
         2'd0:    byte_mask = 32'h0000_00FF;
         2'd1:    byte_mask = 32'h0000_FFFF;
         2'd2:    byte_mask = 32'h00FF_FFFF;
         default: byte_mask = 32'hFFFF_FFFF;
      endcase
      rsp_push    = (state_q == CAPTURE) && rd_q;
      rsp_wdata   = spi_rddata & byte_mask;
      spi_control = {go, 29'b0, nbytes_q};
      spi_wrdata  = wdata_q;
      busy        = (state_q != IDLE) || !cmd_empty;
      timeout_err = timeout_q;
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a behavioural SPI engine model and
// scoreboards for launched commands and returned read data.
module tb_spi_cmd_sequencer;

   localparam logic [31:0] K = 32'h9999_9999;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_wdata = '0;
   logic [1:0]  cmd_nbytes = '0;
   logic        cmd_rd = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [31:0] spi_control;
   logic [31:0] spi_wrdata;
   logic [31:0] spi_rddata = '0;
   logic [31:0] spi_status = 32'h1;
   logic        busy;
   logic        timeout_err;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          go_cnt   = 0;
   int          pop_cnt  = 0;
   int          eng_mode = 0;   // 0 normal, 1 never starts, 2 stays busy
   bit          eng_force_busy = 1'b0;
   bit          eng_active = 1'b0;
   int          eng_cnt = 0;
   logic [1:0]  eng_n;
   logic [31:0] eng_w;
   logic        go_prev = 1'b0;

   logic [33:0] launch_q[$];
   logic [31:0] rsp_q[$];

   spi_cmd_sequencer #(.CMD_DEPTH(8), .RSP_DEPTH(8), .START_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wdata(cmd_wdata),
      .cmd_nbytes(cmd_nbytes), .cmd_rd(cmd_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .spi_control(spi_control), .spi_wrdata(spi_wrdata),
      .spi_rddata(spi_rddata), .spi_status(spi_status),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bmask(input logic [1:0] n);
      logic [31:0] m = '0;
      for (int i = 0; i <= int'(n); i++) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_cmd(input logic rd, input logic [1:0] n, input logic [31:0] w,
                           input bit exp_rsp, input int budget);
      bit ok = 1'b0;
      cmd_valid  = 1'b1;
      cmd_rd     = rd;
      cmd_nbytes = n;
      cmd_wdata  = w;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) ok = 1'b1;
         step();
      end
      cmd_valid = 1'b0;
      check("push_accepted", ok, 1);
      if (ok) begin
         launch_q.push_back({n, w});
         if (rd && exp_rsp) rsp_q.push_back((w ^ K) & bmask(n));
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 400 && (busy !== 1'b0 || rsp_valid !== 1'b0 || eng_active ||
                                  rsp_q.size() != 0); i++)
         @(negedge clk);
      check({tag, "_idle"}, {busy, rsp_valid}, 0);
      check({tag, "_rsp_drained"}, rsp_q.size(), 0);
   endtask

   task automatic wait_go(input string tag);
      for (int i = 0; i < 20 && spi_control[31] !== 1'b1; i++) @(negedge clk);
      check(tag, spi_control[31], 1);
   endtask

   // Engine model: drops idle on go, shifts received bytes into an accumulating register.
   initial begin
      logic [33:0] exp;
      logic [31:0] rx;
      forever begin
         @(posedge clk);
         #1;
         if (spi_control[31] === 1'b1) begin
            check("go_single_pulse", go_prev, 0);
            go_cnt++;
            check("launch_sb_nonempty", launch_q.size() != 0, 1);
            if (launch_q.size() != 0) begin
               exp = launch_q.pop_front();
               check("launch_fields", {spi_control, spi_wrdata},
                     {1'b1, 29'b0, exp[33:32], exp[31:0]});
            end
            if (eng_mode != 1) begin
               eng_active = 1'b1;
               eng_cnt    = 4;
               eng_n      = spi_control[1:0];
               eng_w      = spi_wrdata;
            end
         end else if (eng_active && eng_mode != 2) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               if (busy === 1'b1)
                  check("hold_stable", {spi_control[1:0], spi_wrdata}, {eng_n, eng_w});
               rx = (eng_w ^ K) & bmask(eng_n);
               spi_rddata = (eng_n == 2'd3) ? rx : ((spi_rddata << (8 * (int'(eng_n) + 1))) | rx);
               eng_active = 1'b0;
            end
         end
         spi_status = {31'b0, !(eng_active || eng_force_busy)};
         go_prev    = spi_control[31];
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            check("rsp_sb_nonempty", rsp_q.size() != 0, 1);
            if (rsp_q.size() != 0) check("rsp_data", rsp_data, rsp_q.pop_front());
            pop_cnt++;
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
      $fatal(1);
   end

   initial begin
      int  base_go, base_pop, g;
      bit  any_ready;

      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_control",   spi_control, 0);
      check("rst_wrdata",    spi_wrdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy",      busy, 0);
      check("rst_timeout",   timeout_err, 0);

      // 1-byte read: go two cycles after accept, response two cycles after engine idle
      step();
      push_cmd(1'b1, 2'd0, 32'h0000_00A5, 1'b1, 4);
      @(negedge clk); check("lat_go_c1", spi_control[31], 0);
      @(negedge clk); check("lat_go_c2", spi_control[31], 1);
      for (int i = 0; i < 30 && spi_status[0] !== 1'b1; i++) @(negedge clk);
      @(negedge clk); check("lat_rsp_c1", rsp_valid, 0);
      @(negedge clk); check("lat_rsp_c2", rsp_valid, 1);
      wait_idle("t1");

      step();
      push_cmd(1'b1, 2'd3, 32'hDEAD_BEEF ^ K, 1'b1, 4);
      wait_idle("t2");

      step();
      push_cmd(1'b1, 2'd1, 32'h0000_1234 ^ K, 1'b1, 4);
      push_cmd(1'b1, 2'd2, 32'h00AB_CDEF ^ K, 1'b1, 4);
      push_cmd(1'b0, 2'd3, 32'hCAFE_F00D, 1'b1, 4);
      wait_idle("t3");

      // Ten reads with the consumer stalled: eight fill the response FIFO, then launches stop
      step();
      rsp_ready = 1'b0;
      base_go  = go_cnt;
      base_pop = pop_cnt;
      for (int i = 0; i < 10; i++) push_cmd(1'b1, 2'(i % 4), $urandom, 1'b1, 60);
      repeat (150) @(negedge clk);
      check("stall_go_count",  go_cnt - base_go, 8);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_busy",      busy, 1);
      check("stall_pops",      pop_cnt - base_pop, 0);
      g = go_cnt;
      repeat (30) @(negedge clk);
      check("stall_no_go", go_cnt, g);
      step();
      rsp_ready = 1'b1;
      wait_idle("t4");
      check("drain_go",   go_cnt - base_go, 10);
      check("drain_pops", pop_cnt - base_pop, 10);

      // Engine held busy: command FIFO fills at eight, ninth offer is held off
      step();
      eng_force_busy = 1'b1;
      step();
      step();
      base_go  = go_cnt;
      base_pop = pop_cnt;
      for (int i = 0; i < 8; i++) push_cmd(1'b1, 2'(i % 4), $urandom, 1'b1, 2);
      @(negedge clk);
      check("fill_ready_low", cmd_ready, 0);
      step();
      cmd_valid  = 1'b1;
      cmd_rd     = 1'b0;
      cmd_nbytes = 2'd1;
      cmd_wdata  = 32'h1357_9BDF;
      any_ready  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0) any_ready = 1'b1;
      end
      check("ninth_held",  any_ready, 0);
      check("fill_no_go",  go_cnt - base_go, 0);
      step();
      eng_force_busy = 1'b0;
      push_cmd(1'b0, 2'd1, 32'h1357_9BDF, 1'b1, 100);
      wait_idle("t5");
      check("fill_go",   go_cnt - base_go, 9);
      check("fill_pops", pop_cnt - base_pop, 8);

      // Engine never leaves idle: sticky timeout 15 WAIT_START cycles after go
      step();
      eng_mode = 1;
      push_cmd(1'b1, 2'd0, 32'h0000_005A, 1'b0, 4);
      wait_go("tmo_go");
      repeat (15) @(negedge clk);
      check("tmo_not_yet", timeout_err, 0);
      @(negedge clk);
      check("tmo_set",  timeout_err, 1);
      check("tmo_idle", busy, 0);
      step();
      eng_mode = 0;
      push_cmd(1'b1, 2'd2, 32'h0012_3456, 1'b1, 4);
      wait_idle("t6");
      check("tmo_sticky", timeout_err, 1);

      // Reset while waiting for the engine to finish discards the command
      step();
      eng_mode = 2;
      push_cmd(1'b1, 2'd3, 32'h0102_0304, 1'b0, 4);
      wait_go("wd_go");
      repeat (3) @(negedge clk);
      check("wd_busy_before", busy, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("wd_rst_control",   spi_control, 0);
      check("wd_rst_wrdata",    spi_wrdata, 0);
      check("wd_rst_rsp_valid", rsp_valid, 0);
      check("wd_rst_cmd_ready", cmd_ready, 1);
      check("wd_rst_busy",      busy, 0);
      check("wd_rst_timeout",   timeout_err, 0);
      step();
      eng_mode = 0;
      repeat (20) @(negedge clk);
      check("wd_no_rsp", rsp_valid, 0);

      step();
      push_cmd(1'b1, 2'd0, 32'h0000_0077, 1'b1, 4);
      wait_idle("t8");
      check("launch_sb_empty", launch_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
